// File: rtl/pa_clic_arb.sv
// pa_clic_arb: CLIC interrupt arbiter; scans GRP_NUM sources per cycle for the highest-priority
// pending and enabled source. Optional macro CLIC_ARB_THRESHOLD_EN adds an int_thresh priority filter.
module pa_clic_arb #(
   parameter int INT_NUM    = 64,
   parameter int PRIO_WIDTH = 8,
   parameter int ID_WIDTH   = 6,
   parameter int GRP_NUM    = 8
) (
   input  logic                          forever_cpuclk,
   input  logic                          cpurst_b,
   input  logic                          arb_start,
   input  logic [INT_NUM-1:0]            int_pending,
   input  logic [INT_NUM-1:0]            int_enable,
   input  logic [PRIO_WIDTH*INT_NUM-1:0] int_prio,
`ifdef CLIC_ARB_THRESHOLD_EN
   input  logic [PRIO_WIDTH-1:0]         int_thresh,
`endif
   input  logic                          res_ack,
   output logic                          arb_busy,
   output logic                          res_vld,
   output logic                          res_none,
   output logic [ID_WIDTH-1:0]           res_id,
   output logic [PRIO_WIDTH-1:0]         res_prio,
   output logic [INT_NUM-1:0]            res_onehot
);

   localparam int NGRP  = INT_NUM / GRP_NUM;
   localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam logic [CNT_W-1:0]   LAST_CNT    = CNT_W'(NGRP - 1);
   localparam logic [INT_NUM-1:0] ONE_HOT_LSB = {{(INT_NUM-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_r;
   logic [CNT_W-1:0]        scan_cnt_r;
   logic                    best_vld_r;
   logic [ID_WIDTH-1:0]     best_id_r;
   logic [PRIO_WIDTH-1:0]   best_prio_r;

   logic                    arb_busy_r;
   logic                    res_vld_r;
   logic                    res_none_r;
   logic [ID_WIDTH-1:0]     res_id_r;
   logic [PRIO_WIDTH-1:0]   res_prio_r;
   logic [INT_NUM-1:0]      res_onehot_r;

   logic [INT_NUM-1:0]      src_qual_s;
   logic [PRIO_WIDTH-1:0]   src_prio_s [INT_NUM];
   logic [ID_WIDTH-1:0]     base_s;

   logic                    grp_vld_s;
   logic [ID_WIDTH-1:0]     grp_id_s;
   logic [PRIO_WIDTH-1:0]   grp_prio_s;

   logic                    nxt_vld_s;
   logic [ID_WIDTH-1:0]     nxt_id_s;
   logic [PRIO_WIDTH-1:0]   nxt_prio_s;

   for (genvar i = 0; i < INT_NUM; i++) begin : g_src
      assign src_prio_s[i] = int_prio[i*PRIO_WIDTH +: PRIO_WIDTH];
`ifdef CLIC_ARB_THRESHOLD_EN
      assign src_qual_s[i] = int_pending[i] & int_enable[i] & (src_prio_s[i] > int_thresh);
`else
      assign src_qual_s[i] = int_pending[i] & int_enable[i];
`endif
   end

   assign base_s = ID_WIDTH'(scan_cnt_r) * ID_WIDTH'(GRP_NUM);

   // Group winner: strict compare walking upward keeps the lowest index on equal priority.
   always_comb begin
      grp_vld_s  = 1'b0;
      grp_id_s   = '0;
      grp_prio_s = '0;
      for (int j = 0; j < GRP_NUM; j++) begin
         if (src_qual_s[base_s + ID_WIDTH'(j)] &&
             (!grp_vld_s || (src_prio_s[base_s + ID_WIDTH'(j)] > grp_prio_s))) begin
            grp_vld_s  = 1'b1;
            grp_id_s   = base_s + ID_WIDTH'(j);
            grp_prio_s = src_prio_s[base_s + ID_WIDTH'(j)];
         end else begin
            grp_vld_s  = grp_vld_s;
         end
      end
   end

   // Merge the group winner into the running best; earlier groups win overall ties.
   always_comb begin
      if (grp_vld_s && (!best_vld_r || (grp_prio_s > best_prio_r))) begin
         nxt_vld_s  = 1'b1;
         nxt_id_s   = grp_id_s;
         nxt_prio_s = grp_prio_s;
      end else begin
         nxt_vld_s  = best_vld_r;
         nxt_id_s   = best_id_r;
         nxt_prio_s = best_prio_r;
      end
   end

   // Arbitration FSM with registered result outputs (zero whenever no result is held).
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_r      <= ST_IDLE;
         scan_cnt_r   <= '0;
         best_vld_r   <= 1'b0;
         best_id_r    <= '0;
         best_prio_r  <= '0;
         arb_busy_r   <= 1'b0;
         res_vld_r    <= 1'b0;
         res_none_r   <= 1'b0;
         res_id_r     <= '0;
         res_prio_r   <= '0;
         res_onehot_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (arb_start) begin
                  state_r     <= ST_SCAN;
                  scan_cnt_r  <= '0;
                  best_vld_r  <= 1'b0;
                  best_id_r   <= '0;
                  best_prio_r <= '0;
                  arb_busy_r  <= 1'b1;
               end
            end
            ST_SCAN: begin
               best_vld_r  <= nxt_vld_s;
               best_id_r   <= nxt_id_s;
               best_prio_r <= nxt_prio_s;
               if (scan_cnt_r == LAST_CNT) begin
                  state_r      <= ST_DONE;
                  scan_cnt_r   <= '0;
                  res_vld_r    <= 1'b1;
                  res_none_r   <= ~nxt_vld_s;
                  res_id_r     <= nxt_vld_s ? nxt_id_s : '0;
                  res_prio_r   <= nxt_vld_s ? nxt_prio_s : '0;
                  res_onehot_r <= nxt_vld_s ? (ONE_HOT_LSB << nxt_id_s) : '0;
               end else begin
                  scan_cnt_r <= scan_cnt_r + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (res_ack) begin
                  state_r      <= ST_IDLE;
                  arb_busy_r   <= 1'b0;
                  res_vld_r    <= 1'b0;
                  res_none_r   <= 1'b0;
                  res_id_r     <= '0;
                  res_prio_r   <= '0;
                  res_onehot_r <= '0;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               scan_cnt_r   <= '0;
               best_vld_r   <= 1'b0;
               arb_busy_r   <= 1'b0;
               res_vld_r    <= 1'b0;
               res_none_r   <= 1'b0;
               res_id_r     <= '0;
               res_prio_r   <= '0;
               res_onehot_r <= '0;
            end
         endcase
      end
   end

   assign arb_busy   = arb_busy_r;
   assign res_vld    = res_vld_r;
   assign res_none   = res_none_r;
   assign res_id     = res_id_r;
   assign res_prio   = res_prio_r;
   assign res_onehot = res_onehot_r;

endmodule

// File: tb/tb_pa_clic_arb.sv
// Scoreboard bench for pa_clic_arb: stimulus pushes expected results, a negedge monitor checks them.
module tb_pa_clic_arb;

   logic          clk;
   logic          cpurst_b;
   logic          arb_start;
   logic [63:0]   int_pending;
   logic [63:0]   int_enable;
   logic [511:0]  int_prio;
`ifdef CLIC_ARB_THRESHOLD_EN
   logic [7:0]    int_thresh;
`endif
   logic          res_ack;
   logic          arb_busy;
   logic          res_vld;
   logic          res_none;
   logic [5:0]    res_id;
   logic [7:0]    res_prio;
   logic [63:0]   res_onehot;

   typedef struct packed {
      logic       none;
      logic [5:0] id;
      logic [7:0] prio;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   episodes = 0;
   logic prev_vld = 1'b0;

   pa_clic_arb dut (
      .forever_cpuclk (clk),
      .cpurst_b       (cpurst_b),
      .arb_start      (arb_start),
      .int_pending    (int_pending),
      .int_enable     (int_enable),
      .int_prio       (int_prio),
`ifdef CLIC_ARB_THRESHOLD_EN
      .int_thresh     (int_thresh),
`endif
      .res_ack        (res_ack),
      .arb_busy       (arb_busy),
      .res_vld        (res_vld),
      .res_none       (res_none),
      .res_id         (res_id),
      .res_prio       (res_prio),
      .res_onehot     (res_onehot)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic none, input logic [5:0] id, input logic [7:0] prio);
      exp_t e;
      e.none = none;
      e.id   = id;
      e.prio = prio;
      return e;
   endfunction

   // Monitor: each rising res_vld episode is compared against the head of the scoreboard.
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] oh;
      if (res_vld && !prev_vld) begin
         episodes++;
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
         end else begin
            e  = exp_q.pop_front();
            oh = e.none ? 64'd0 : (64'd1 << e.id);
            chk("res_none", {63'd0, res_none}, {63'd0, e.none});
            chk("res_id", {58'd0, res_id}, {58'd0, e.id});
            chk("res_prio", {56'd0, res_prio}, {56'd0, e.prio});
            chk("res_onehot", res_onehot, oh);
            chk("busy_in_done", {63'd0, arb_busy}, 64'd1);
         end
      end else if (!res_vld) begin
         chk("idle_onehot_zero", res_onehot, 64'd0);
         chk("idle_fields_zero", {49'd0, res_none, res_id, res_prio}, 64'd0);
      end
      prev_vld = res_vld;
   end

   task automatic clear_src();
      int_pending = 64'd0;
      int_enable  = 64'd0;
      int_prio    = 512'd0;
   endtask

   task automatic set_src(input int i, input logic [7:0] p);
      int_pending[i]     = 1'b1;
      int_enable[i]      = 1'b1;
      int_prio[i*8 +: 8] = p;
   endtask

   // One pass: checks start-to-res_vld latency; optionally adds a source late in the scan.
   task automatic run_pass(input exp_t e, input string nm, input int late_cyc,
                           input int late_src, input logic [7:0] late_prio);
      int cyc;
      exp_q.push_back(e);
      @(posedge clk); #1 arb_start = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1 arb_start = 1'b0;
         cyc++;
         if (cyc == late_cyc) set_src(late_src, late_prio);
      end while (!res_vld && cyc < 40);
      chk({nm, "_latency"}, 64'(cyc), 64'd9);
   endtask

   task automatic do_ack(input string nm);
      chk({nm, "_vld_before_ack"}, {63'd0, res_vld}, 64'd1);
      res_ack = 1'b1;
      @(posedge clk); #1 res_ack = 1'b0;
      chk({nm, "_vld_after_ack"}, {63'd0, res_vld}, 64'd0);
      chk({nm, "_busy_after_ack"}, {63'd0, arb_busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int ep0;
      clk = 1'b0; cpurst_b = 1'b1; arb_start = 1'b0; res_ack = 1'b0;
      clear_src();
`ifdef CLIC_ARB_THRESHOLD_EN
      int_thresh = 8'd0;
`endif
      #2 cpurst_b = 1'b0;
      #20;
      chk("rst_busy", {63'd0, arb_busy}, 64'd0);
      chk("rst_vld", {63'd0, res_vld}, 64'd0);
      chk("rst_onehot", res_onehot, 64'd0);
      @(negedge clk) cpurst_b = 1'b1;

      // Two sources in different groups, higher priority later.
      clear_src(); set_src(5, 8'd3); set_src(40, 8'd9);
      run_pass(mk(1'b0, 6'd40, 8'd9), "two_src", 0, 0, 8'd0);
      do_ack("two_src");

      // Equal max priority across groups; hold without ack.
      clear_src(); set_src(7, 8'hFF); set_src(12, 8'hFF); set_src(63, 8'hFF);
      run_pass(mk(1'b0, 6'd7, 8'hFF), "tie_ff", 0, 0, 8'd0);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (res_vld !== 1'b1 || res_id !== 6'd7 || res_prio !== 8'hFF ||
             res_none !== 1'b0 || res_onehot !== (64'd1 << 7) || arb_busy !== 1'b1) bad++;
      end
      chk("hold_unstable_cycles", 64'(bad), 64'd0);
      do_ack("tie_ff");

      // All pending, none enabled.
      clear_src(); int_pending = {64{1'b1}}; int_prio = {64{8'h80}};
      run_pass(mk(1'b1, 6'd0, 8'd0), "none_en", 0, 0, 8'd0);
      do_ack("none_en");

      // Tie inside one group plus a lower one elsewhere.
      clear_src(); set_src(10, 8'd7); set_src(9, 8'd7); set_src(2, 8'd6);
      run_pass(mk(1'b0, 6'd9, 8'd7), "grp_tie", 0, 0, 8'd0);
      do_ack("grp_tie");

      // Overall tie between groups with higher later priority absent.
      clear_src(); set_src(50, 8'd5); set_src(3, 8'd5); set_src(49, 8'd4);
      run_pass(mk(1'b0, 6'd3, 8'd5), "xgrp_tie", 0, 0, 8'd0);
      do_ack("xgrp_tie");

      // Source in an already-scanned group appears late: missed.
      clear_src(); set_src(60, 8'd1);
      run_pass(mk(1'b0, 6'd60, 8'd1), "late_missed", 2, 2, 8'd200);
      do_ack("late_missed");

      // Source in a not-yet-scanned group appears late: seen.
      clear_src(); set_src(60, 8'd1);
      run_pass(mk(1'b0, 6'd63, 8'd200), "late_seen", 2, 63, 8'd200);
      do_ack("late_seen");

`ifndef CLIC_ARB_THRESHOLD_EN
      // Priority zero still qualifies.
      clear_src(); set_src(20, 8'd0);
      run_pass(mk(1'b0, 6'd20, 8'd0), "prio0", 0, 0, 8'd0);
      do_ack("prio0");
`endif

      // Reset during scan cycle 4, then a clean pass.
      clear_src(); set_src(5, 8'd3); set_src(40, 8'd9);
      @(posedge clk); #1 arb_start = 1'b1;
      @(posedge clk); #1 arb_start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("scan_busy", {63'd0, arb_busy}, 64'd1);
      cpurst_b = 1'b0;
      #1;
      chk("midrst_busy", {63'd0, arb_busy}, 64'd0);
      chk("midrst_vld", {63'd0, res_vld}, 64'd0);
      chk("midrst_onehot", res_onehot, 64'd0);
      chk("midrst_fields", {49'd0, res_none, res_id, res_prio}, 64'd0);
      @(negedge clk) cpurst_b = 1'b1;
      repeat (12) @(posedge clk);
      #1 chk("postrst_idle", {62'd0, res_vld, arb_busy}, 64'd0);
      run_pass(mk(1'b0, 6'd40, 8'd9), "after_rst", 0, 0, 8'd0);
      do_ack("after_rst");

      // arb_start during SCAN and together with res_ack in DONE is ignored; res_ack in SCAN too.
      ep0 = episodes;
      clear_src(); set_src(33, 8'h44);
      exp_q.push_back(mk(1'b0, 6'd33, 8'h44));
      @(posedge clk); #1 arb_start = 1'b1;
      @(posedge clk); #1 arb_start = 1'b0;
      repeat (2) @(posedge clk);
      #1 arb_start = 1'b1; res_ack = 1'b1;
      @(posedge clk); #1 arb_start = 1'b0; res_ack = 1'b0;
      for (int k = 0; k < 20 && !res_vld; k++) begin
         @(posedge clk); #1;
      end
      chk("ign_vld_seen", {63'd0, res_vld}, 64'd1);
      arb_start = 1'b1; res_ack = 1'b1;
      @(posedge clk); #1 arb_start = 1'b0; res_ack = 1'b0;
      chk("ign_vld_after_ack", {63'd0, res_vld}, 64'd0);
      repeat (15) @(posedge clk);
      #1 chk("ign_busy_after", {63'd0, arb_busy}, 64'd0);
      chk("ign_episodes", 64'(episodes - ep0), 64'd1);

`ifdef CLIC_ARB_THRESHOLD_EN
      clear_src(); set_src(5, 8'd9); set_src(6, 8'd10); int_thresh = 8'd9;
      run_pass(mk(1'b0, 6'd6, 8'd10), "thresh9", 0, 0, 8'd0);
      do_ack("thresh9");
      int_thresh = 8'd10;
      run_pass(mk(1'b1, 6'd0, 8'd0), "thresh10", 0, 0, 8'd0);
      do_ack("thresh10");
      int_thresh = 8'd0;
`endif

      repeat (3) @(posedge clk);
      #1 chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
